// File: rtl/ospi_ram_arbiter_if.sv
// ospi_ram_arbiter_if
//   Bundles the three buses around the frame-RAM arbiter:
//   - port A : OSPI slave engine, bus-timed, never stalled (a_en/a_we/a_addr/a_wdata/a_rdata)
//   - port B : auxiliary requester, valid/ready in, rvalid/rdata out
//   - RAM    : single-port RAM, combinational request, 1-cycle read latency
//   Modports:
//   - slave  : the arbiter's view
//   - master : the view of the surrounding requesters and the RAM
interface ospi_ram_arbiter_if #(
   parameter int ADDR_W = 18,
   parameter int DATA_W = 8
);
   // port A
   logic              a_en;
   logic              a_we;
   logic [ADDR_W-1:0] a_addr;
   logic [DATA_W-1:0] a_wdata;
   logic [DATA_W-1:0] a_rdata;
   // port B
   logic              b_valid;
   logic              b_ready;
   logic              b_we;
   logic [ADDR_W-1:0] b_addr;
   logic [DATA_W-1:0] b_wdata;
   logic              b_rvalid;
   logic [DATA_W-1:0] b_rdata;
   // RAM
   logic              ram_en;
   logic              ram_we;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_wdata;
   logic [DATA_W-1:0] ram_rdata;

   modport slave (
      input  a_en, a_we, a_addr, a_wdata,
      output a_rdata,
      input  b_valid, b_we, b_addr, b_wdata,
      output b_ready, b_rvalid, b_rdata,
      output ram_en, ram_we, ram_addr, ram_wdata,
      input  ram_rdata
   );

   modport master (
      output a_en, a_we, a_addr, a_wdata,
      input  a_rdata,
      output b_valid, b_we, b_addr, b_wdata,
      input  b_ready, b_rvalid, b_rdata,
      input  ram_en, ram_we, ram_addr, ram_wdata,
      output ram_rdata
   );
endinterface

// File: rtl/ospi_ram_arbiter.sv
// ospi_ram_arbiter
//   Shares the single-port frame RAM between the OSPI slave engine (port A)
//   and an auxiliary requester (port B). Port A always owns the RAM in any
//   cycle it asserts a_en. Port B is captured in a one-entry holding register
//   and issued in the first cycle port A leaves the RAM free.
//   Ports:
//   - clk        : single clock, rising edge
//   - reset      : asynchronous, active-high
//   - bus        : port A / port B / RAM signals (ospi_ram_arbiter_if.slave)
//   - starve_clr : clears the sticky starvation flag
//   - starve     : sticky, port B waited MAX_WAIT cycles behind port A
module ospi_ram_arbiter #(
   parameter int ADDR_W   = 18,
   parameter int DATA_W   = 8,
   parameter int MAX_WAIT = 1024,
   parameter int WAIT_W   = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   ospi_ram_arbiter_if.slave    bus,
   input  logic                 starve_clr,
   output logic                 starve
);

   typedef enum logic [1:0] {IDLE, PEND, RESP} state_t;

   state_t            state, state_nxt;
   logic              hold_we;
   logic [ADDR_W-1:0] hold_addr;
   logic [DATA_W-1:0] hold_wdata;
   logic [WAIT_W-1:0] wait_cnt, wait_nxt;
   logic              accept;
   logic              starve_set;

   // next-state / handshake
   always_comb begin
      state_nxt  = state;
      wait_nxt   = wait_cnt;
      accept     = 1'b0;
      starve_set = 1'b0;
      case (state)
         IDLE: begin
            if (bus.b_valid) begin
               accept    = 1'b1;
               state_nxt = PEND;
            end
         end
         PEND: begin
            if (bus.a_en) begin
               // saturating, so the MAX_WAIT crossing happens at most once per request
               if (wait_cnt != '1) begin
                  wait_nxt   = wait_cnt + 1'b1;
                  starve_set = (wait_cnt == WAIT_W'(MAX_WAIT - 1));
               end
            end else begin
               wait_nxt  = '0;
               state_nxt = hold_we ? IDLE : RESP;
            end
         end
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // RAM port mux: A wins whenever it is active, B only from the holding register
   always_comb begin
      bus.ram_en    = 1'b0;
      bus.ram_we    = 1'b0;
      bus.ram_addr  = hold_addr;
      bus.ram_wdata = hold_wdata;
      if (bus.a_en) begin
         bus.ram_en    = 1'b1;
         bus.ram_we    = bus.a_we;
         bus.ram_addr  = bus.a_addr;
         bus.ram_wdata = bus.a_wdata;
      end else if (state == PEND) begin
         bus.ram_en = 1'b1;
         bus.ram_we = hold_we;
      end
   end

   assign bus.a_rdata = bus.ram_rdata;
   assign bus.b_ready = (state == IDLE);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         wait_cnt   <= '0;
         hold_we    <= 1'b0;
         hold_addr  <= '0;
         hold_wdata <= '0;
         bus.b_rvalid <= 1'b0;
         bus.b_rdata  <= '0;
         starve     <= 1'b0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_nxt;
         if (accept) begin
            hold_we    <= bus.b_we;
            hold_addr  <= bus.b_addr;
            hold_wdata <= bus.b_wdata;
         end
         // RESP is the cycle the RAM presents B's read data
         bus.b_rvalid <= (state == RESP);
         if (state == RESP)
            bus.b_rdata <= bus.ram_rdata;
         // set dominates a simultaneous clear
         starve <= starve_set | (starve & ~starve_clr);
      end
   end

endmodule
